// File: rtl/spi_frame_loader.sv
// SPI frame loader: receives LEDS*3 RGB bytes over a mode-0 SPI link into a
// back buffer, then swaps it to the front for the NeoPixel driver once the
// driver is idle. A frame is accepted only if it is exactly LEDS*3 whole bytes.
module spi_frame_loader #(
  parameter int LEDS = 30,
  parameter int AW   = $clog2(LEDS * 3)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_spi_sck,
  input  logic          i_spi_cs_n,
  input  logic          i_spi_mosi,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_drv_start,
  input  logic          i_drv_busy,
  output logic          o_rx_active,
  output logic          o_frame_err,
  output logic          o_frame_drop
);

  localparam int NBYTES = LEDS * 3;
  // Byte counter must be able to hold NBYTES itself, not just NBYTES-1.
  localparam int CW = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_WAIT_BUSY
  } state_e;

  // Synchronizer chains; *_prev_q holds the previous synchronized value for
  // edge detection.
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  // Control state.
  state_e        state_q, state_d;
  logic          rx_active_q, rx_active_d;
  logic          drop_pend_q, drop_pend_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic          overflow_q, overflow_d;
  logic [6:0]    shift_q, shift_d;
  logic          front_sel_q, front_sel_d;
  logic          drv_start_q, drv_start_d;
  logic          frame_err_q, frame_err_d;
  logic          frame_drop_q, frame_drop_d;
  logic [1:0]    settle_q, settle_d;
  logic          armed_q, armed_d;

  // Edge strobes and byte-write controls.
  logic          sck_rise, cs_fall, cs_rise;
  logic          bit_sample, byte_done, wr_en;
  logic [7:0]    rx_byte;
  logic [AW-1:0] wr_addr;

  // Two frame buffers; front_sel_q names the one the driver reads.
  logic [7:0] buf0 [NBYTES];
  logic [7:0] buf1 [NBYTES];

  // Bring the asynchronous SPI pins into the i_clk domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value
      // of its predecessor, which is what turns this into a real shift chain.
      sck_meta_q  <= i_spi_sck;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      cs_meta_q   <= i_spi_cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      mosi_meta_q <= i_spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  // Edge detection on the synchronized pins. A CS fall only counts once CS
  // has been seen high after reset, so a transaction that was already in
  // progress at reset release is never picked up halfway.
  always_comb begin
    sck_rise   = sck_sync_q & ~sck_prev_q;
    cs_fall    = ~cs_sync_q & cs_prev_q & armed_q;
    cs_rise    = cs_sync_q & ~cs_prev_q;
    bit_sample = sck_rise & rx_active_q & ~cs_sync_q;
    byte_done  = bit_sample & (bit_cnt_q == 3'd7);
    rx_byte    = {shift_q, mosi_sync_q};
    wr_en      = byte_done & (byte_cnt_q < CW'(NBYTES));
    wr_addr    = AW'(byte_cnt_q);
  end

  // Next-state logic for reception, frame validation and buffer swap.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    rx_active_d  = rx_active_q;
    drop_pend_d  = drop_pend_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    overflow_d   = overflow_q;
    shift_d      = shift_q;
    front_sel_d  = front_sel_q;
    drv_start_d  = 1'b0;
    frame_err_d  = 1'b0;
    frame_drop_d = 1'b0;
    settle_d     = {settle_q[0], 1'b1};
    // The CS synchronizer holds its reset value for two cycles; only trust
    // it after that.
    armed_d      = armed_q | (settle_q[1] & cs_sync_q);

    // Shift in one bit per SCK rising edge, MSB first.
    if (bit_sample) begin
      shift_d   = {shift_q[5:0], mosi_sync_q};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    // Bytes past the end of the frame are counted as overflow, not stored.
    if (byte_done) begin
      if (byte_cnt_q < CW'(NBYTES)) begin
        byte_cnt_d = byte_cnt_q + CW'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end

    // Start of a transaction: accept it only when no frame is outstanding.
    if (cs_fall) begin
      if (state_q == ST_IDLE) begin
        rx_active_d = 1'b1;
        bit_cnt_d   = 3'd0;
        byte_cnt_d  = '0;
        overflow_d  = 1'b0;
      end else begin
        drop_pend_d = 1'b1;
      end
    end

    // End of a transaction: validate an accepted one, report a dropped one.
    if (cs_rise) begin
      if (rx_active_q) begin
        rx_active_d = 1'b0;
        if ((byte_cnt_q == CW'(NBYTES)) && (bit_cnt_q == 3'd0) && !overflow_q) begin
          state_d = ST_PENDING;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      if (drop_pend_q) begin
        drop_pend_d  = 1'b0;
        frame_drop_d = 1'b1;
      end
    end

    // Hand the completed frame to the driver once it is idle, then wait for
    // it to acknowledge by going busy.
    case (state_q)
      ST_PENDING: begin
        if (!i_drv_busy) begin
          front_sel_d = ~front_sel_q;
          drv_start_d = 1'b1;
          state_d     = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (i_drv_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  // Control registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      rx_active_q  <= 1'b0;
      drop_pend_q  <= 1'b0;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      shift_q      <= 7'd0;
      front_sel_q  <= 1'b0;
      drv_start_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_drop_q <= 1'b0;
      settle_q     <= 2'b00;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_active_q  <= rx_active_d;
      drop_pend_q  <= drop_pend_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      overflow_q   <= overflow_d;
      shift_q      <= shift_d;
      front_sel_q  <= front_sel_d;
      drv_start_q  <= drv_start_d;
      frame_err_q  <= frame_err_d;
      frame_drop_q <= frame_drop_d;
      settle_q     <= settle_d;
      armed_q      <= armed_d;
    end
  end

  // Received bytes always go to the back buffer (the one not selected).
  // NOTE: buffer storage has no reset; its contents are only meaningful after
  // a complete frame has been loaded and swapped in.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      if (front_sel_q) begin
        buf0[wr_addr] <= rx_byte;
      end else begin
        buf1[wr_addr] <= rx_byte;
      end
    end
  end

  // Combinational front-buffer read port; out-of-range addresses read zero.
  always_comb begin
    o_rd_data = 8'h00;
    if (int'(i_rd_addr) < NBYTES) begin
      o_rd_data = front_sel_q ? buf1[i_rd_addr] : buf0[i_rd_addr];
    end
  end

  assign o_drv_start  = drv_start_q;
  assign o_rx_active  = rx_active_q;
  assign o_frame_err  = frame_err_q;
  assign o_frame_drop = frame_drop_q;

endmodule

// File: doc/spi_frame_loader.md
SPI_FRAME_LOADER -- requirements
Module: spi_frame_loader

Interface
REQ-001 Parameter LEDS, default 30, number of LEDs; a frame is exactly LEDS*3 bytes (R,G,B order per LED).
REQ-002 Parameter AW, default $clog2(LEDS*3), byte address width.
REQ-003 i_clk  in  1  system clock, single clock domain for all logic.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_spi_sck  in  1  SPI clock from host, asynchronous to i_clk, mode 0.
REQ-006 i_spi_cs_n  in  1  SPI chip select, active-low, asynchronous to i_clk.
REQ-007 i_spi_mosi  in  1  SPI data, MSB first.
REQ-008 i_rd_addr  in  AW  read address from the NeoPixel driver.
REQ-009 o_rd_data  out  8  front-buffer byte at i_rd_addr.
REQ-010 o_drv_start  out  1  one-cycle start pulse to the driver.
REQ-011 i_drv_busy  in  1  driver busy flag.
REQ-012 o_rx_active  out  1  high while a transaction is being accepted.
REQ-013 o_frame_err  out  1  one-cycle pulse: transaction ended with byte count != LEDS*3 or with a partial byte.
REQ-014 o_frame_drop  out  1  one-cycle pulse: a transaction was ignored because a frame was still pending.

Function
REQ-015 SCK, CS_N, and MOSI each pass through a 2-flop synchronizer; the SCK sync flops reset to 0 and the CS_N sync flops reset to 1.
REQ-016 The SCK period is at least 8 i_clk periods; the block samples MOSI on the synchronized SCK rising edge.
REQ-017 Two byte buffers of LEDS*3 entries each (front, back) and a front-select bit, reset 0, are provided; buffer contents are not reset.
REQ-018 o_rd_data is combinational: front[i_rd_addr]; it is 0x00 for i_rd_addr >= LEDS*3.
REQ-019 On a synchronized CS_N falling edge with state IDLE, the block clears the bit and byte counters and raises o_rx_active.
REQ-020 Every 8th sampled bit writes the assembled byte to back[byte_cnt], then increments byte_cnt.
REQ-021 Bytes with byte_cnt >= LEDS*3 are not written; they set an overflow flag.
REQ-022 On a synchronized CS_N rising edge the block clears o_rx_active.
REQ-023 At that CS_N rising edge, if byte_cnt == LEDS*3, bit_cnt == 0, and overflow == 0, the state goes to PENDING.
REQ-024 At that CS_N rising edge in any other case, the block pulses o_frame_err and the state stays IDLE.
REQ-025 States are IDLE, PENDING and WAIT_BUSY.
REQ-026 PENDING and i_drv_busy == 0 -> the front-select bit toggles, o_drv_start pulses in the same cycle, and the state goes to WAIT_BUSY.
REQ-027 WAIT_BUSY -> IDLE when i_drv_busy == 1 is sampled; o_drv_start is never reasserted in WAIT_BUSY.
REQ-028 A CS_N falling edge in PENDING or WAIT_BUSY is ignored entirely (no writes, o_rx_active low); the block pulses o_frame_drop at the matching CS_N rising edge.
REQ-029 Swap and o_drv_start never occur while o_rx_active == 1 for the same buffer, because writes always target the back buffer.
REQ-030 The front buffer never changes while i_drv_busy == 1.
REQ-031 SCK edges while synchronized CS_N is high are ignored.

Reset
REQ-032 While i_rst_n == 0: o_drv_start = 0, o_frame_err = 0, o_frame_drop = 0, o_rx_active = 0, state = IDLE, counters = 0, overflow = 0.
REQ-033 Reset mid-transaction discards that transaction; if CS_N is low at reset release, no bytes are accepted until CS_N rises and falls again.
REQ-034 Reset in PENDING or WAIT_BUSY discards the pending frame; no o_drv_start is issued.

Verification
REQ-035 The bench sends 90 bytes, byte k = k, with i_drv_busy = 0 -> one o_drv_start pulse 3-4 cycles after CS_N rises; afterwards o_rd_data at addr 0/45/89 = 0x00/0x2D/0x59.
REQ-036 The bench sends 89 bytes, then repeats with 90 bytes plus 3 bits -> one o_frame_err pulse for each transaction, no o_drv_start, front buffer unchanged.
REQ-037 The bench sends 91 bytes -> overflow, o_frame_err, and back[89] holds the 90th byte, not the 91st.
REQ-038 The bench holds i_drv_busy = 1 and sends a valid frame -> no start while busy; the bench drops busy -> o_drv_start in the next cycle, and read data switches only then.
REQ-039 The bench sends a second frame while PENDING -> o_frame_drop pulses, and the back-buffer contents equal the first frame.
REQ-040 The bench asserts i_rst_n low at byte 40 with CS_N still low -> all outputs are 0, and no bytes are accepted until a fresh CS_N fall; a following valid frame starts normally.
